// File: rtl/if_stage_pipe_pkg.sv
// Shared definitions for the instruction-fetch stage: reset PC default,
// bus size encoding, instruction-buffer entry layout and FSM state type.
package if_stage_pipe_pkg;

    // First fetch address after reset unless the top overrides it.
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c00_0000;

    // Bus size encoding for a 32-bit word access.
    localparam logic [1:0]  SIZE_WORD = 2'b10;

    // One buffered fetch result: address-error flag, PC and instruction word.
    typedef struct packed {
        logic        adef;
        logic [31:0] pc;
        logic [31:0] inst;
    } ibuf_entry_t;

    localparam int ENTRY_W = $bits(ibuf_entry_t);

    // Request FSM: REQ may issue a fetch, WAIT holds the single outstanding one.
    typedef enum logic {
        ST_REQ  = 1'b0,
        ST_WAIT = 1'b1
    } fetch_state_t;

    // A fetch address must be word aligned; anything else becomes an ADEF marker.
    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/if_stage_pipe_ibuf.sv
// Small register-based FIFO holding fetched instructions between the bus
// response and ID. Head is visible combinationally from the storage registers,
// so an entry pushed at an edge is presented in the following cycle.
// Flush clears everything and wins over a coincident push or pop.
module if_ibuf #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(DEPTH - 1);

    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Pointers wrap explicitly so a depth of 1 behaves like any other size.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Pop only real entries; push only into free space (a same-cycle pop frees one).
    assign do_pop  = pop  && !flush && (count_reg != '0);
    assign do_push = push && !flush && ((count_reg != FULL_COUNT) || do_pop);

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (do_pop) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // One storage register per entry, written when the write pointer selects it.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [WIDTH-1:0] entry_reg;

            // Capture the pushed word into this slot.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    entry_reg <= '0;
                end else if (do_push && (wr_ptr_reg == PTR_W'(gi))) begin
                    entry_reg <= din;
                end
            end

            assign mem_q[gi] = entry_reg;
        end
    endgenerate

    assign dout  = mem_q[rd_ptr_reg];
    assign empty = (count_reg == '0);
    assign count = count_reg;

endmodule

// File: rtl/if_stage_pipe.sv
// Instruction-fetch stage: issues word fetches on a request/response SRAM-like
// bus with one request in flight, buffers results in if_ibuf, and hands them
// to ID with a valid/allowin handshake. A branch redirect flushes the buffer
// and marks any in-flight fetch so its response is discarded. A misaligned
// fetch PC is not sent to the bus; an ADEF marker entry is queued instead and
// fetching halts until the next redirect.
module if_stage_pipe
    import if_stage_pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          IBUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        ds_allowin,
    output logic        fs_to_ds_valid,
    output logic [31:0] fs_pc,
    output logic [31:0] fs_inst,
    output logic        fs_adef,
    output logic        inst_sram_req,
    output logic        inst_sram_wr,
    output logic [1:0]  inst_sram_size,
    output logic [3:0]  inst_sram_wstrb,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic        inst_sram_addr_ok,
    input  logic        inst_sram_data_ok,
    input  logic [31:0] inst_sram_rdata
);

    localparam int               CNT_W     = $clog2(IBUF_DEPTH + 1);
    localparam logic [CNT_W-1:0] IBUF_FULL = CNT_W'(IBUF_DEPTH);

    fetch_state_t state_reg;
    logic [31:0]  fetch_pc_reg;
    logic [31:0]  req_pc_reg;
    logic         cancel_reg;
    logic         halt_reg;

    logic [CNT_W-1:0] ibuf_count;
    logic             ibuf_empty;
    ibuf_entry_t      push_entry;
    ibuf_entry_t      head_entry;

    logic can_issue;
    logic can_admit;
    logic fetch_misaligned;
    logic issue_req;
    logic req_hs;
    logic adef_push;
    logic resp_push;
    logic ibuf_push;
    logic ibuf_pop;

    // Admission: only in REQ, not halted, and only while the buffer has room,
    // which also guarantees room for the response when it returns.
    assign can_issue        = (state_reg == ST_REQ) && !halt_reg;
    assign can_admit        = ibuf_count < IBUF_FULL;
    assign fetch_misaligned = is_misaligned(fetch_pc_reg);

    // Request is held low while reset is asserted so the bus sees nothing.
    assign issue_req = !reset && can_issue && can_admit && !fetch_misaligned;
    assign req_hs    = issue_req && inst_sram_addr_ok;

    // Two push sources are mutually exclusive by FSM state.
    assign adef_push = can_issue && can_admit && fetch_misaligned;
    assign resp_push = (state_reg == ST_WAIT) && inst_sram_data_ok && !cancel_reg;
    assign ibuf_push = (adef_push || resp_push) && !br_taken;
    assign ibuf_pop  = fs_to_ds_valid && ds_allowin;

    // Build the entry to enqueue: ADEF marker carries the bad PC and no data.
    always_comb begin
        push_entry = '0;
        if (adef_push) begin
            push_entry.adef = 1'b1;
            push_entry.pc   = fetch_pc_reg;
            push_entry.inst = 32'h0;
        end else begin
            push_entry.adef = 1'b0;
            push_entry.pc   = req_pc_reg;
            push_entry.inst = inst_sram_rdata;
        end
    end

    if_ibuf #(
        .WIDTH (ENTRY_W),
        .DEPTH (IBUF_DEPTH)
    ) u_ibuf (
        .clk   (clk),
        .reset (reset),
        .push  (ibuf_push),
        .pop   (ibuf_pop),
        .flush (br_taken),
        .din   (push_entry),
        .dout  (head_entry),
        .empty (ibuf_empty),
        .count (ibuf_count)
    );

    // Request FSM with fetch PC, in-flight PC, cancel and halt tracking.
    // A redirect takes priority over every other update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= ST_REQ;
            fetch_pc_reg <= RESET_PC;
            req_pc_reg   <= 32'h0;
            cancel_reg   <= 1'b0;
            halt_reg     <= 1'b0;
        end else if (br_taken) begin
            fetch_pc_reg <= br_target;
            halt_reg     <= 1'b0;
            if (state_reg == ST_WAIT) begin
                if (inst_sram_data_ok) begin
                    // Response lands this cycle: drop it here, nothing left in flight.
                    cancel_reg <= 1'b0;
                    state_reg  <= ST_REQ;
                end else begin
                    // Response still to come: discard it when it arrives.
                    cancel_reg <= 1'b1;
                    state_reg  <= ST_WAIT;
                end
            end else if (req_hs) begin
                // The old-path request was accepted just now; its data is stale.
                req_pc_reg <= fetch_pc_reg;
                cancel_reg <= 1'b1;
                state_reg  <= ST_WAIT;
            end
        end else begin
            case (state_reg)
                ST_REQ: begin
                    if (req_hs) begin
                        req_pc_reg   <= fetch_pc_reg;
                        fetch_pc_reg <= fetch_pc_reg + 32'd4;
                        state_reg    <= ST_WAIT;
                    end else if (adef_push) begin
                        halt_reg <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (inst_sram_data_ok) begin
                        cancel_reg <= 1'b0;
                        state_reg  <= ST_REQ;
                    end
                end
                default: state_reg <= ST_REQ;
            endcase
        end
    end

    // ID-side view of the buffer head; fields read zero when nothing is valid.
    assign fs_to_ds_valid = !ibuf_empty;
    assign fs_pc          = fs_to_ds_valid ? head_entry.pc   : 32'h0;
    assign fs_inst        = fs_to_ds_valid ? head_entry.inst : 32'h0;
    assign fs_adef        = fs_to_ds_valid && head_entry.adef;

    // Bus request side; this stage only ever reads whole words.
    assign inst_sram_req   = issue_req;
    assign inst_sram_addr  = issue_req ? fetch_pc_reg : 32'h0;
    assign inst_sram_wr    = 1'b0;
    assign inst_sram_size  = SIZE_WORD;
    assign inst_sram_wstrb = 4'h0;
    assign inst_sram_wdata = 32'h0;

endmodule

// File: tb/tb_if_stage_pipe.sv
// Bench for if_stage_pipe: directed scenarios followed by randomized bus
// timing, allowin and redirects, checked against a fetch-stream model that
// tracks the expected next fetch address and the queue of entries ID should see.
module tb_if_stage_pipe;

    localparam logic [31:0] RESET_PC = 32'h1c00_0000;
    localparam int          DEPTH    = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        br_taken;
    logic [31:0] br_target;
    logic        ds_allowin;
    logic        fs_to_ds_valid;
    logic [31:0] fs_pc;
    logic [31:0] fs_inst;
    logic        fs_adef;
    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;

    if_stage_pipe #(
        .RESET_PC   (RESET_PC),
        .IBUF_DEPTH (DEPTH)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .br_taken          (br_taken),
        .br_target         (br_target),
        .ds_allowin        (ds_allowin),
        .fs_to_ds_valid    (fs_to_ds_valid),
        .fs_pc             (fs_pc),
        .fs_inst           (fs_inst),
        .fs_adef           (fs_adef),
        .inst_sram_req     (inst_sram_req),
        .inst_sram_wr      (inst_sram_wr),
        .inst_sram_size    (inst_sram_size),
        .inst_sram_wstrb   (inst_sram_wstrb),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_wdata   (inst_sram_wdata),
        .inst_sram_addr_ok (inst_sram_addr_ok),
        .inst_sram_data_ok (inst_sram_data_ok),
        .inst_sram_rdata   (inst_sram_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adef;
    } ent_t;

    // Model state: entries ID should receive, in order, and next fetch address.
    ent_t        exp_q[$];
    logic [31:0] hs_log[$];
    logic [31:0] m_pc;
    bit          m_halt;

    // Bus slave state.
    bit          bus_busy;
    bit          bus_stale;
    logic [31:0] bus_addr;
    int          bus_wait;

    // Stimulus knobs.
    bit aok_rand, aok_fixed, dok_rand, dly_rand, allow_rand, allow_fixed;
    int dly_fixed;

    int n_asserts = 0;
    int n_fail    = 0;
    int hs_cnt    = 0;
    int pop_cnt   = 0;

    // Memory contents as a fixed function of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9e37_79b1) ^ 32'h5a5a_0f0f;
    endfunction

    task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] expv);
        n_asserts++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One clock cycle: drive inputs, check observed bus/ID traffic, advance model.
    task automatic cycle(input bit br, input logic [31:0] tgt);
        bit   dok, hs, pop;
        ent_t e;
        br_taken          = br;
        br_target         = br ? tgt : 32'h0;
        inst_sram_addr_ok = aok_rand ? ($urandom_range(0, 2) != 0) : aok_fixed;
        dok               = bus_busy && (bus_wait == 0) && (dok_rand ? ($urandom_range(0, 1) == 1) : 1'b1);
        inst_sram_data_ok = dok;
        inst_sram_rdata   = dok ? mem_word(bus_addr) : $urandom;
        ds_allowin        = allow_rand ? ($urandom_range(0, 3) != 0) : allow_fixed;
        #1;
        hs  = inst_sram_req && inst_sram_addr_ok;
        pop = fs_to_ds_valid && ds_allowin && !br;
        if (inst_sram_req) begin
            chk("req_allowed", ((!bus_busy || bus_stale) && !m_halt && (exp_q.size() < DEPTH)), 1'b1);
        end
        if (hs) begin
            chk("req_addr", inst_sram_addr, m_pc);
        end
        if (pop) begin
            pop_cnt++;
            chk("pop_nonempty", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("pop_entry", {fs_adef, fs_pc, fs_inst}, {e.adef, e.pc, e.inst});
            end
            $display("pop pc=%08h inst=%08h adef=%0b", fs_pc, fs_inst, fs_adef);
        end
        if (dok) begin
            bus_busy  = 1'b0;
            bus_stale = 1'b0;
        end else if (bus_busy && bus_wait > 0) begin
            bus_wait--;
        end
        if (br) begin
            exp_q.delete();
            m_pc   = tgt;
            m_halt = 1'b0;
            if (tgt[1:0] != 2'b00) begin
                exp_q.push_back('{tgt, 32'h0, 1'b1});
                m_halt = 1'b1;
            end
        end
        if (hs) begin
            hs_cnt++;
            hs_log.push_back(inst_sram_addr);
            bus_busy = 1'b1;
            bus_addr = inst_sram_addr;
            bus_wait = dly_rand ? int'($urandom_range(0, 3)) : dly_fixed;
            if (!br) begin
                exp_q.push_back('{m_pc, mem_word(m_pc), 1'b0});
                m_pc = m_pc + 32'd4;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_hs(input string tag, input int max_cycles);
        int start;
        start = hs_cnt;
        for (int i = 0; i < max_cycles && hs_cnt == start; i++) begin
            cycle(1'b0, 32'h0);
        end
        chk(tag, hs_cnt != start, 1'b1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] tgt;
        int          guard;
        int          p0;

        reset = 1'b1; br_taken = 1'b0; br_target = 32'h0; ds_allowin = 1'b0;
        inst_sram_addr_ok = 1'b0; inst_sram_data_ok = 1'b0; inst_sram_rdata = 32'h0;
        m_pc = RESET_PC; m_halt = 1'b0;
        bus_busy = 1'b0; bus_stale = 1'b0; bus_addr = 32'h0; bus_wait = 0;
        aok_rand = 1'b0; aok_fixed = 1'b1; dok_rand = 1'b0; dly_rand = 1'b0; dly_fixed = 0;
        allow_rand = 1'b0; allow_fixed = 1'b1;
        @(negedge clk);
        @(negedge clk);

        // Reset state: everything quiet, constants as wired.
        chk("rst_req",   inst_sram_req,  1'b0);
        chk("rst_addr",  inst_sram_addr, 32'h0);
        chk("rst_valid", fs_to_ds_valid, 1'b0);
        chk("rst_pc",    fs_pc,          32'h0);
        chk("rst_inst",  fs_inst,        32'h0);
        chk("rst_adef",  fs_adef,        1'b0);
        chk("const_bus", {inst_sram_wr, inst_sram_size, inst_sram_wstrb, inst_sram_wdata},
                         {1'b0, 2'b10, 4'h0, 32'h0});
        reset = 1'b0;

        // Sequential fetch with one-cycle response latency.
        hs_log.delete();
        cycle(1'b0, 32'h0);
        cycle(1'b0, 32'h0);
        chk("t1_latency_valid", fs_to_ds_valid, 1'b1);
        chk("t1_latency_pc",    fs_pc,          RESET_PC);
        repeat (6) cycle(1'b0, 32'h0);
        chk("t1_addr0", hs_log[0], RESET_PC);
        chk("t1_addr1", hs_log[1], RESET_PC + 32'd4);
        chk("t1_addr2", hs_log[2], RESET_PC + 32'd8);

        // Backpressure: buffer fills to depth and requests stop.
        allow_fixed = 1'b0;
        repeat (10) cycle(1'b0, 32'h0);
        chk("t2_req_blocked", inst_sram_req,  1'b0);
        chk("t2_valid",       fs_to_ds_valid, 1'b1);
        chk("t2_head_pc",     fs_pc,          exp_q[0].pc);
        allow_fixed = 1'b1;
        p0 = pop_cnt;
        wait_hs("t2_resume", 10);
        chk("t2_buffered_pops", pop_cnt - p0, 2);

        // Redirect while a response is outstanding.
        dly_fixed = 3;
        wait_hs("t3_hs", 10);
        cycle(1'b1, 32'h1c00_0100);
        hs_log.delete();
        guard = 0;
        while (hs_log.size() == 0 && guard < 12) begin
            chk("t3_no_stale", fs_to_ds_valid, 1'b0);
            cycle(1'b0, 32'h0);
            guard++;
        end
        chk("t3_redirect_seen", hs_log.size() != 0, 1'b1);
        chk("t3_redirect_addr", hs_log[0], 32'h1c00_0100);

        // Redirect coincident with the response.
        dly_fixed = 0;
        wait_hs("t4_hs", 10);
        cycle(1'b1, 32'h1c00_0300);
        chk("t4_ibuf_empty", fs_to_ds_valid, 1'b0);
        chk("t4_req",        inst_sram_req,  1'b1);
        chk("t4_addr",       inst_sram_addr, 32'h1c00_0300);

        // Misaligned redirect target becomes an ADEF entry, then fetch halts.
        cycle(1'b1, 32'h1c00_0102);
        guard = 0;
        while (!fs_to_ds_valid && guard < 12) begin
            cycle(1'b0, 32'h0);
            guard++;
        end
        chk("t5_adef", fs_adef, 1'b1);
        chk("t5_pc",   fs_pc,   32'h1c00_0102);
        chk("t5_inst", fs_inst, 32'h0);
        cycle(1'b0, 32'h0);
        repeat (4) cycle(1'b0, 32'h0);
        chk("t5_idle_req",   inst_sram_req,  1'b0);
        chk("t5_idle_valid", fs_to_ds_valid, 1'b0);
        hs_log.delete();
        cycle(1'b1, 32'h1c00_0200);
        wait_hs("t5_resume", 10);
        chk("t5_resume_addr", hs_log[0], 32'h1c00_0200);

        // Reset in the middle of an outstanding fetch.
        dly_fixed = 3;
        wait_hs("t6_hs", 10);
        br_taken = 1'b0;
        inst_sram_addr_ok = 1'b0;
        inst_sram_data_ok = 1'b0;
        reset = 1'b1;
        #1;
        chk("t6_rst_req",   inst_sram_req,  1'b0);
        chk("t6_rst_addr",  inst_sram_addr, 32'h0);
        chk("t6_rst_valid", fs_to_ds_valid, 1'b0);
        chk("t6_rst_pc",    fs_pc,          32'h0);
        chk("t6_rst_inst",  fs_inst,        32'h0);
        chk("t6_rst_adef",  fs_adef,        1'b0);
        exp_q.delete();
        m_pc = RESET_PC;
        m_halt = 1'b0;
        bus_stale = bus_busy;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
        aok_fixed = 1'b0;
        bus_wait = 0;
        cycle(1'b0, 32'h0);
        chk("t6_stale_dropped", fs_to_ds_valid, 1'b0);
        aok_fixed = 1'b1;
        hs_log.delete();
        wait_hs("t6_hs_after", 5);
        chk("t6_first_addr", hs_log[0], RESET_PC);

        // Randomized bus timing, backpressure and redirects.
        aok_rand = 1'b1; dok_rand = 1'b1; dly_rand = 1'b1; allow_rand = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                tgt = RESET_PC + ($urandom_range(0, 255) << 2);
                if ($urandom_range(0, 3) == 0) begin
                    tgt[1:0] = 2'($urandom_range(1, 3));
                end
                cycle(1'b1, tgt);
            end else begin
                cycle(1'b0, 32'h0);
            end
        end

        // Drain: halt on a misaligned target and let ID take everything.
        allow_rand = 1'b0;
        allow_fixed = 1'b1;
        cycle(1'b1, 32'h1c00_0ffe);
        repeat (40) cycle(1'b0, 32'h0);
        chk("drain_empty", exp_q.size(), 0);
        chk("drain_valid", fs_to_ds_valid, 1'b0);
        chk("drain_req",   inst_sram_req,  1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/if_stage_pipe.md
Name: if_stage_pipe

Overview:
- Next-generation instruction-fetch stage for the LoongArch pipeline.
- Replaces the always-fetch, fixed-latency IF with a request/response SRAM-like bus (addr_ok/data_ok), a parametrised instruction buffer, and a valid/allowin handshake to ID.
- Handles branch redirects with cancellation of in-flight fetches.
- Flags misaligned fetch addresses (ADEF) instead of issuing them.

Parameters:
- RESET_PC, 32'h1c000000, first fetch address after reset.
- IBUF_DEPTH, 2, instruction-buffer entries; power of two, >= 1.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- br_taken  in  1  redirect pulse from ID/EX
- br_target  in  32  redirect address
- ds_allowin  in  1  ID can accept an entry this cycle
- fs_to_ds_valid  out  1  head entry valid
- fs_pc  out  32  PC of head entry
- fs_inst  out  32  instruction of head entry; 0 when fs_adef=1
- fs_adef  out  1  head entry is an address-error marker
- inst_sram_req  out  1  fetch request
- inst_sram_wr  out  1  constant 0
- inst_sram_size  out  2  constant 2'b10
- inst_sram_wstrb  out  4  constant 0
- inst_sram_addr  out  32  fetch address
- inst_sram_wdata  out  32  constant 0
- inst_sram_addr_ok  in  1  request accepted this cycle
- inst_sram_data_ok  in  1  response valid this cycle
- inst_sram_rdata  in  32  response data

Behaviour:
- Reset (asynchronous): fetch_pc=RESET_PC, state=REQ, cancel=0, halt=0, ibuf empty. All outputs read 0.
- Single outstanding request. Request FSM has two states: REQ and WAIT.
- REQ:
  - inst_sram_req=1 when halt=0 and ibuf_count < IBUF_DEPTH; inst_sram_addr=fetch_pc.
  - On req&&addr_ok: req_pc<=fetch_pc, fetch_pc<=fetch_pc+4 (32-bit wrap), go to WAIT.
  - While addr_ok=0, the address may change; the bus allows this.
- WAIT:
  - inst_sram_req=0.
  - On data_ok: if cancel=1, drop the data and clear cancel. Otherwise push {req_pc, rdata, adef=0}. Return to REQ.
  - Space is guaranteed because admission checked count < DEPTH and pops only free entries.
- Latency: data_ok in cycle t gives fs_to_ds_valid=1 in cycle t+1. The ibuf is registered; there is no bypass.
- Pop: fs_to_ds_valid && ds_allowin removes the head. Push and pop may occur in the same cycle; count is unchanged.
- br_taken (highest priority):
  - Flush ibuf (count=0, no pop reported).
  - fetch_pc<=br_target; halt<=0.
  - If state=WAIT without data_ok, or REQ with addr_ok in the same cycle: cancel<=1 (next data_ok is dropped), state=WAIT.
  - If data_ok arrives in the same cycle: drop the data, no cancel, state=REQ.
  - A push coincident with br_taken is suppressed.
- Misaligned fetch: in REQ, with halt=0, fetch_pc[1:0]!=0 and space available:
  - No bus request.
  - Push {fetch_pc, 32'h0, adef=1}; halt<=1.
  - Fetching resumes only on the next br_taken.
- cancel=1 never allows a second request to be issued; the FSM stays in WAIT until the cancelled response returns.
- Constants wr/size/wstrb/wdata are driven as listed in Ports.

Decomposition:
- Shared package/header: RESET_PC default, SIZE_WORD=2'b10, ibuf entry layout {adef, pc[31:0], inst[31:0]} = 65 bits.
- Sub-module if_ibuf: synchronous FIFO with these properties:
  - parameters WIDTH and DEPTH
  - inputs push, pop, flush; outputs empty, count
  - flush dominates push and pop
  - asynchronous reset

Test Plan:
1. Reset release, addr_ok tied 1, data_ok 1 cycle after each request, ds_allowin=1 -> addresses 0x1c000000, 0x1c000004, 0x1c000008; fs_pc follows one cycle after each data_ok.
2. ds_allowin=0 with IBUF_DEPTH=2 -> exactly 2 entries buffered, inst_sram_req stays 0. Raise ds_allowin -> entries pop in order, then requests resume.
3. br_taken to 0x1c000100 while in WAIT -> the pending response is dropped, the next request address is 0x1c000100, and no stale fs_pc appears.
4. br_taken in the same cycle as data_ok -> data is not pushed, ibuf is empty next cycle, and the next request address is br_target.
5. br_taken to 0x1c000102 -> no bus request, entry fs_adef=1 with fs_pc=0x1c000102 and fs_inst=0, then idle. A later br_taken to 0x1c000200 resumes fetch.
6. Assert reset during WAIT -> all outputs 0 immediately. After release, the first request is to RESET_PC and the late data_ok from before reset is not pushed (cancel semantics on re-entry).
